// File: rtl/cpuy_prog_loader.sv
// cpuy_prog_loader
//   Program-memory responder for the CPU instruction fetch bus. Owns a
//   DEPTH x 8 program RAM. It loads a framed image (LEN_H, LEN_L, payload,
//   CSUM) from a byte-stream valid/ready port and verifies the image. The CPU
//   is held in reset until a good image is resident.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   load_start          one-cycle pulse, begins a new image load
//   load_valid/_data    image byte stream
//   load_ready          byte accepted this cycle when load_valid is also high
//   addr_bus/data_bus   CPU fetch port, 1-cycle registered read
//   cpu_rst             CPU reset (high = held in reset)
//   loaded              valid image resident, CPU running
//   error               last load failed (length or checksum)
module cpuy_prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] addr_bus,
    output logic [7:0]        data_bus,
    output logic              cpu_rst,
    output logic              loaded,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE, LEN_H, LEN_L, DATA, CSUM, RUN, ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t            state, state_nx;
    logic [7:0]        len_h;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   remaining;
    logic [7:0]        sum;
    logic [7:0]        ram [DEPTH];

    logic [15:0] len_n;
    logic        xfer;

    assign len_n = {len_h, load_data};
    assign xfer  = load_valid & load_ready;

    always_comb begin
        load_ready = 1'b0;
        case (state)
            LEN_H, LEN_L, DATA, CSUM: load_ready = 1'b1;
            default:                  load_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RUN, ERROR: if (load_start) state_nx = LEN_H;
            LEN_H: if (xfer) state_nx = LEN_L;
            LEN_L: if (xfer) begin
                if ({1'b0, len_n} > DEPTH_W) state_nx = ERROR;
                else if (len_n == 16'd0)     state_nx = CSUM;
                else                         state_nx = DATA;
            end
            // exit on the byte count, not wr_ptr, so a full-DEPTH image
            // whose pointer wraps to 0 still terminates correctly
            DATA: if (xfer && remaining == (ADDR_W+1)'(1)) state_nx = CSUM;
            CSUM: if (xfer) state_nx = (load_data == sum) ? RUN : ERROR;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs are registered off the next state so cpu_rst drops on
    // the very edge that accepts a good CSUM, and rises on the edge that
    // sees load_start in RUN. Any load spends at least LEN_H, LEN_L and CSUM
    // with cpu_rst high, which covers the CPU's 2-step reset counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_h     <= 8'h00;
            wr_ptr    <= '0;
            remaining <= '0;
            sum       <= 8'h00;
            cpu_rst   <= 1'b1;
            loaded    <= 1'b0;
            error     <= 1'b0;
        end else begin
            state   <= state_nx;
            cpu_rst <= (state_nx != RUN);
            loaded  <= (state_nx == RUN);
            error   <= (state_nx == ERROR);
            if (xfer) begin
                case (state)
                    LEN_H: len_h <= load_data;
                    LEN_L: begin
                        wr_ptr    <= '0;
                        remaining <= len_n[ADDR_W:0];
                        sum       <= 8'h00;
                    end
                    DATA: begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        sum       <= sum + load_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM is never cleared; a reset mid-load leaves partial contents behind.
    always_ff @(posedge clk) begin
        if (!rst && state == DATA && xfer)
            ram[wr_ptr] <= load_data;
    end

    // Read-before-write on a same-address collision: old data is returned.
    always_ff @(posedge clk) begin
        if (rst) data_bus <= 8'h00;
        else     data_bus <= ram[addr_bus];
    end

endmodule

// File: tb/tb_cpuy_prog_loader.sv
module tb_cpuy_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_ready;
    logic [11:0] addr_bus = 12'h000;
    logic [7:0]  data_bus;
    logic        cpu_rst;
    logic        loaded;
    logic        error;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int hi_cnt = 0;
    int lo_cnt = 0;

    cpuy_prog_loader #(.ADDR_W(12), .DEPTH(4096)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready),
        .addr_bus(addr_bus), .data_bus(data_bus),
        .cpu_rst(cpu_rst), .loaded(loaded), .error(error)
    );

    always #5 clk = ~clk;

    // inputs change 1 time unit after posedge, so negedge sees what the
    // next posedge will see
    always @(negedge clk) begin
        if (load_valid && load_ready) acc_cnt++;
        if (cpu_rst) hi_cnt++;
        else         lo_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        load_valid = 1'b1;
        load_data  = b;
        while (!load_ready && n < 10) begin
            tick();
            n++;
        end
        chk("send_ready", 16'(load_ready), 16'h1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic read(input logic [11:0] a, input logic [7:0] exp, input string tag);
        addr_bus = a;
        tick();
        chk(tag, 16'(data_bus), 16'(exp));
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_loaded"}, 16'(loaded), 16'h1);
        chk({tag, "_cpu_rst"}, 16'(cpu_rst), 16'h0);
        chk({tag, "_error"}, 16'(error), 16'h0);
        chk({tag, "_ready"}, 16'(load_ready), 16'h0);
    endtask

    initial begin
        int a0, h0, l0;
        logic [7:0] rl [5];
        rl[0] = 8'h00; rl[1] = 8'h02; rl[2] = 8'hAA; rl[3] = 8'h55; rl[4] = 8'hFF;

        // reset state
        tick(); tick();
        chk("rst_ready", 16'(load_ready), 16'h0);
        chk("rst_cpu_rst", 16'(cpu_rst), 16'h1);
        chk("rst_loaded", 16'(loaded), 16'h0);
        chk("rst_error", 16'(error), 16'h0);
        chk("rst_data_bus", 16'(data_bus), 16'h00);
        rst = 1'b0;
        tick();
        chk("idle_cpu_rst", 16'(cpu_rst), 16'h1);

        // 1: nominal load
        pulse_start();
        send(8'h00); send(8'h03); send(8'h80); send(8'h12); send(8'h34);
        chk("s1_pre_csum_cpu_rst", 16'(cpu_rst), 16'h1);
        send(8'hC6);
        chk_run("s1");
        read(12'h001, 8'h12, "s1_fetch1");
        read(12'h002, 8'h34, "s1_fetch2");

        // 2: bad checksum, then recovery
        pulse_start();
        send(8'h00); send(8'h03); send(8'h80); send(8'h12); send(8'h34); send(8'hC7);
        chk("s2_error", 16'(error), 16'h1);
        chk("s2_cpu_rst", 16'(cpu_rst), 16'h1);
        chk("s2_loaded", 16'(loaded), 16'h0);
        chk("s2_ready", 16'(load_ready), 16'h0);
        pulse_start();
        chk("s2_error_clear", 16'(error), 16'h0);
        send(8'h00); send(8'h03); send(8'h80); send(8'h12); send(8'h34); send(8'hC6);
        chk_run("s2");

        // 3: oversize length, then full-depth image with pointer wrap
        pulse_start();
        send(8'h10); send(8'h01);
        chk("s3_error", 16'(error), 16'h1);
        chk("s3_ready", 16'(load_ready), 16'h0);
        read(12'h000, 8'h80, "s3_no_write");
        pulse_start();
        send(8'h10); send(8'h00);
        chk("s3_data_ready", 16'(load_ready), 16'h1);
        chk("s3_data_error", 16'(error), 16'h0);
        a0 = acc_cnt;
        load_valid = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            load_data = 8'(i);
            tick();
        end
        load_valid = 1'b0;
        chk("s3_accepted", 16'(acc_cnt - a0), 16'd4096);
        chk("s3_csum_wait", 16'(loaded), 16'h0);
        send(8'h00); // 16 * sum(0..255) wraps to 0
        chk_run("s3");
        read(12'h000, 8'h00, "s3_ram0");
        read(12'h005, 8'h05, "s3_ram5");
        read(12'hFFF, 8'hFF, "s3_ramFFF");

        // 4: zero length, then reload with valid toggling
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00);
        chk_run("s4_zero");
        pulse_start();
        a0 = acc_cnt; h0 = hi_cnt; l0 = lo_cnt;
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1;
            load_data  = rl[k];
            tick();
            load_valid = 1'b0;
            if (k < 4) tick();
        end
        chk("s4_accepted", 16'(acc_cnt - a0), 16'd5);
        chk("s4_cpu_rst_low_cycles", 16'(lo_cnt - l0), 16'd0);
        chk("s4_cpu_rst_hi_ge2", 16'((hi_cnt - h0) >= 2), 16'h1);
        chk_run("s4");
        read(12'h000, 8'hAA, "s4_ram0");
        read(12'h001, 8'h55, "s4_ram1");

        // 5: reload from RUN, ignored load_start, mid-load reset
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("s5_cpu_rst_reassert", 16'(cpu_rst), 16'h1);
        chk("s5_loaded_drop", 16'(loaded), 16'h0);
        chk("s5_ready", 16'(load_ready), 16'h1);
        send(8'h00); send(8'h04); send(8'h11); send(8'h22);
        pulse_start();
        send(8'h33); send(8'h44); send(8'hAA);
        chk_run("s5_ignored_start");
        read(12'h002, 8'h33, "s5_ram2");
        pulse_start();
        send(8'h00); send(8'h04); send(8'h55); send(8'h66);
        rst = 1'b1;
        tick();
        chk("s5_rst_data_bus", 16'(data_bus), 16'h00);
        rst = 1'b0;
        tick();
        chk("s5_rst_ready", 16'(load_ready), 16'h0);
        chk("s5_rst_cpu_rst", 16'(cpu_rst), 16'h1);
        chk("s5_rst_loaded", 16'(loaded), 16'h0);
        chk("s5_rst_error", 16'(error), 16'h0);
        read(12'h000, 8'h55, "s5_stale0");
        read(12'h002, 8'h33, "s5_stale2");
        chk("s5_idle_hold", 16'(load_ready), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpuy_prog_loader.md
Name: cpuy_prog_loader

Overview:
Program-memory responder for the CPU's external instruction fetch bus. It owns a DEPTH x 8 program RAM and answers CPU fetches (`addr_bus` in, `data_bus` out). Before a program runs, it accepts a framed program image over a byte-stream valid/ready loader port, checks the image, and holds the CPU in reset until a valid image is in memory. It sits between the board-level loader (UART/SPI byte source) and the CPU core.

Parameters:
ADDR_W, 12, fetch address width; matches CPU `addr_bus`.
DEPTH, 4096, program RAM bytes; must equal 2**ADDR_W.

Ports:
clk  in  1  system clock; all state on posedge.
rst  in  1  reset, synchronous, active-high.
load_start  in  1  one-cycle pulse; begins a new image load.
load_valid  in  1  load_data holds a byte.
load_data  in  8  image byte.
load_ready  out  1  block accepts a byte this cycle.
addr_bus  in  ADDR_W  CPU fetch address.
data_bus  out  8  fetched byte.
cpu_rst  out  1  drives the CPU rst input; high holds the CPU in reset.
loaded  out  1  a valid image is resident and the CPU is running.
error  out  1  last load failed (bad length or checksum).

Behaviour:
- Reset values: load_ready=0, cpu_rst=1, loaded=0, error=0, data_bus=8'h00, state=IDLE, wr_ptr=0, remaining=0, sum=0. RAM contents are not cleared.
- Image frame: LEN_H, LEN_L (big-endian byte count N), N payload bytes, CSUM. CSUM equals the 8-bit wrap-around sum of the payload bytes. Payload is written to addresses 0..N-1.
- Byte transfer occurs on a posedge where load_valid & load_ready. load_valid may drop at any time; no byte is lost or duplicated.
- load_ready=1 only in LEN_H, LEN_L, DATA, CSUM.
- States and transitions:
  - IDLE: cpu_rst=1. load_start moves to LEN_H.
  - LEN_H: capture the high byte, then go to LEN_L.
  - LEN_L: form N.
    - N > DEPTH: go to ERROR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA, with wr_ptr=0, remaining=N, sum=0.
  - DATA: each accepted byte writes `ram[wr_ptr]`, then wr_ptr+1, remaining-1, sum+=byte. When the last byte is accepted (remaining==1), go to CSUM.
  - CSUM: if the byte equals sum, go to RUN; otherwise go to ERROR.
  - RUN: cpu_rst=0, loaded=1, error=0. load_start moves to LEN_H and reasserts cpu_rst in the same cycle, giving the CPU a synchronous reset.
  - ERROR: cpu_rst=1, error=1, loaded=0. load_start moves to LEN_H and clears error.
- load_start is ignored in LEN_H, LEN_L, DATA and CSUM; the load in progress continues.
- cpu_rst and loaded are registered outputs.
  - On CSUM->RUN, cpu_rst goes 0 on the posedge that accepts the CSUM byte.
  - cpu_rst is guaranteed high for at least 2 full clock cycles before release. This satisfies the CPU's 2-step reset counter sampled on negedge.
- Fetch port:
  - `data_bus <= ram[addr_bus]` on every posedge, in all states: 1-cycle registered read.
  - The CPU updates `addr_bus` on negedge and samples `data_bus` on the following negedge, so the intervening posedge presents valid data.
  - Same-address read/write in one cycle returns old data. This is only possible while cpu_rst=1.
- DEPTH-byte image (N=4096): wr_ptr wraps to 0 after the final write. This is harmless because DATA exits on the remaining count, not on wr_ptr.
- rst mid-load: return to IDLE, cpu_rst=1. Partially written RAM stays stale. loaded=0, error=0.

Test Plan:
1. Nominal load: after rst, pulse load_start; stream 00 03 80 12 34 C6 with load_valid held high. Required: RUN, cpu_rst=0, loaded=1. With addr_bus=001, data_bus=8'h12 one posedge later; with addr_bus=002, data_bus=8'h34.
2. Bad checksum: stream 00 03 80 12 34 C7. Required: ERROR, error=1, cpu_rst=1, loaded=0. A subsequent load_start plus the valid frame from scenario 1 reaches RUN with error=0.
3. Oversize length: stream 10 01. Required: ERROR immediately after LEN_L, load_ready=0, no RAM write (address 000 keeps its prior value). Length 10 00 is accepted and enters DATA.
4. Zero length and backpressure: stream 00 00 00 → RUN. Then reload 00 02 AA 55 FF with load_valid toggling 1/0 every cycle. Required: exactly 5 bytes accepted, `ram[0]=AA`, `ram[1]=55`, RUN; cpu_rst high throughout the reload and for ≥2 cycles.
5. Reload and mid-load reset: from RUN, pulse load_start → cpu_rst=1 in the same cycle. Assert rst after 2 payload bytes → IDLE, cpu_rst=1, loaded=0, error=0, load_ready=0. load_start during DATA is ignored.
